cursor_paint_ctrl: RTL and testbench
====================================

Name: cursor_paint_ctrl

Overview:
Consumes decoded mouse packets (buttons plus signed 8-bit deltas with a one-cycle data_valid strobe) from the upstream mouse receiver. It integrates the deltas into a cursor position clamped to the canvas. It issues pixel-write requests to the framebuffer writer over a valid/ready interface: single-pixel paint while the left button is held, a palette step on each right-button press, and a full-canvas clear on each middle-button press.

Parameters:
SCREEN_W, 64, canvas width in pixels
SCREEN_H, 64, canvas height in pixels
X_W, 6, cursor_x width (must satisfy 2^X_W >= SCREEN_W)
Y_W, 6, cursor_y width (must satisfy 2^Y_W >= SCREEN_H)
ADDR_W, 12, framebuffer address width (must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_left  in  1  packet left button; sampled only when data_valid=1
btn_right  in  1  packet right button; sampled only when data_valid=1
btn_middle  in  1  packet middle button; sampled only when data_valid=1
delta_x  in  8  signed two's-complement X motion; positive moves right
delta_y  in  8  signed two's-complement Y motion; positive moves up, i.e. row decreases
data_valid  in  1  one-cycle packet strobe
cursor_x  out  X_W  current column
cursor_y  out  Y_W  current row
color_idx  out  3  current palette index
wr_valid  out  1  pixel write request
wr_addr  out  ADDR_W  pixel address, computed as y*SCREEN_W + x
wr_color  out  3  pixel palette index
wr_ready  in  1  framebuffer accepts the write when wr_valid and wr_ready are both 1
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - cursor_x=SCREEN_W/2, cursor_y=SCREEN_H/2, color_idx=1.
  - wr_valid=0, wr_addr=0, wr_color=0, busy=0.
  - Previous-button registers=0, pending buffer empty, state=IDLE.
  - A reset during PAINT or CLEAR abandons the operation. wr_valid must drop in the same instant as reset.
- Pending buffer (one entry):
  - Any data_valid strobe is captured into the pending buffer, in every state including the cycle the FSM leaves IDLE.
  - If the buffer is already full, dx/dy are added to the stored sums, sign-extended to 10 bits and saturated at -512/+511. Button bits are replaced by the newest packet's bits.
- FSM states: IDLE, UPDATE, PAINT, CLEAR.
- IDLE: if the pending buffer is full, or data_valid=1 this cycle, go to UPDATE. A data_valid in this cycle is used directly, merged with any pending entry. The buffer is emptied.
- UPDATE (exactly one cycle):
  - new_x = clamp(cursor_x + dx, 0, SCREEN_W-1).
  - new_y = clamp(cursor_y - dy, 0, SCREEN_H-1).
  - Use signed 12-bit intermediates; no wrap-around.
  - If btn_right=1 and prev_right=0, color_idx increments modulo 8 (7 -> 0).
  - prev_* registers are updated from the packet.
  - Cursor and color registers update at the end of UPDATE, so new values are visible 2 cycles after the data_valid strobe.
  - Next state, in priority order:
    - middle rising edge -> CLEAR, with the clear counter set to 0;
    - otherwise btn_left=1 -> PAINT;
    - otherwise -> IDLE.
- PAINT:
  - wr_valid=1, wr_addr=new_y*SCREEN_W+new_x, wr_color=the updated color_idx.
  - wr_addr and wr_color are held stable until wr_ready=1.
  - On handshake: wr_valid=0 next cycle, state -> IDLE.
- CLEAR:
  - wr_valid=1, wr_addr=clear counter, wr_color=0.
  - On each handshake the counter increments. After the handshake at address SCREEN_W*SCREEN_H-1, wr_valid=0 and state -> IDLE.
  - The cursor and color are unchanged by CLEAR.
  - Left-button paint is not performed for the packet that triggered CLEAR.
- wr_valid is never deasserted before its handshake, except by reset.
- At most one write is outstanding. Throughput is one write per cycle while wr_ready is held at 1.

Test Plan:
- Reset with SCREEN_W=SCREEN_H=64 -> cursor (32,32), color_idx=1, wr_valid=0, busy=0.
- Packet dx=+5, dy=+3, no buttons -> cursor (37,29) exactly 2 cycles after the strobe; no write is issued.
- Clamp: from x=37, dx=0x80 (-128) -> x=0; from x=60, dx=+127 -> x=63; from y=2, dy=+10 -> y=0.
- Left held, dx=+1 at (37,29), wr_ready low for 3 cycles -> wr_valid held with wr_addr=1894 (29*64+38) and wr_color=1 stable; exactly one handshake occurs, then the FSM returns to IDLE.
- Right-button press sequence 0,1,1,0,1 starting from color 7 -> color goes 7 -> 0 at the first edge, then 0 -> 1 at the second edge only. Middle press with wr_ready=1 -> 4096 consecutive writes at addresses 0..4095 with color 0, busy=1 throughout.
- Two packets (dx=+3, then dx=+4) strobed during a stalled PAINT -> merged into a single UPDATE with dx=+7. Reset asserted mid-CLEAR -> wr_valid=0 immediately and the cursor returns to (32,32).

Source files
------------

// File: rtl/cursor_paint_ctrl_if.sv
// Pixel-write bus between the cursor/paint controller and the framebuffer writer.
// The master holds wr_addr/wr_color stable while wr_valid waits for wr_ready.
interface cursor_paint_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_color;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_color, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_color, output wr_ready);
endinterface

// File: rtl/cursor_paint_ctrl.sv
// Cursor integration and paint controller: accumulates mouse packets into a
// clamped cursor position and issues pixel writes (paint, palette step, clear).
module cursor_paint_ctrl #(
  parameter int SCREEN_W = 64,
  parameter int SCREEN_H = 64,
  parameter int X_W      = 6,
  parameter int Y_W      = 6,
  parameter int ADDR_W   = 12
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_middle,
  input  logic signed [7:0]   delta_x,
  input  logic signed [7:0]   delta_y,
  input  logic                data_valid,
  output logic [X_W-1:0]      cursor_x,
  output logic [Y_W-1:0]      cursor_y,
  output logic [2:0]          color_idx,
  cursor_paint_ctrl_if.master wr,
  output logic                busy
);

  localparam logic [ADDR_W-1:0]   LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);
  localparam logic signed [11:0]  X_MAX     = 12'(SCREEN_W - 1);
  localparam logic signed [11:0]  Y_MAX     = 12'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, PAINT, CLEAR} state_t;

  state_t state;

  // One-entry pending buffer (stage 0) and the packet being applied (stage 1)
  logic                    pend_full;
  logic signed [9:0]       pend_dx_p0, pend_dy_p0;
  logic                    pend_l_p0, pend_r_p0, pend_m_p0;
  logic signed [9:0]       upd_dx_p1, upd_dy_p1;
  logic                    upd_l_p1, upd_r_p1, upd_m_p1;

  logic                    prev_right, prev_middle;
  logic [ADDR_W-1:0]       clr_cnt;
  logic                    wr_valid_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [2:0]              wr_color_q;

  logic signed [9:0]       in_dx, in_dy, mrg_dx, mrg_dy;
  logic signed [11:0]      cx, cy, dx12, dy12, nx, ny;
  logic [X_W-1:0]          new_x;
  logic [Y_W-1:0]          new_y;
  logic [2:0]              new_color;
  logic [ADDR_W-1:0]       paint_addr;

  function automatic logic signed [9:0] sat10(input logic signed [10:0] s);
    if (s > 11'sd511)       return 10'sd511;
    else if (s < -11'sd512) return -10'sd512;
    else                    return s[9:0];
  endfunction

  function automatic logic signed [11:0] clamp12(input logic signed [11:0] v,
                                                 input logic signed [11:0] hi);
    if (v < 12'sd0)   return 12'sd0;
    else if (v > hi)  return hi;
    else              return v;
  endfunction

  // Packet merge and cursor/colour/address arithmetic for the UPDATE cycle
  always_comb begin
    in_dx      = {{2{delta_x[7]}}, delta_x};
    in_dy      = {{2{delta_y[7]}}, delta_y};
    mrg_dx     = pend_full ? sat10({pend_dx_p0[9], pend_dx_p0} + {in_dx[9], in_dx}) : in_dx;
    mrg_dy     = pend_full ? sat10({pend_dy_p0[9], pend_dy_p0} + {in_dy[9], in_dy}) : in_dy;
    cx         = $signed({{(12-X_W){1'b0}}, cursor_x});
    cy         = $signed({{(12-Y_W){1'b0}}, cursor_y});
    dx12       = {{2{upd_dx_p1[9]}}, upd_dx_p1};
    dy12       = {{2{upd_dy_p1[9]}}, upd_dy_p1};
    nx         = clamp12(cx + dx12, X_MAX);
    ny         = clamp12(cy - dy12, Y_MAX);
    new_x      = nx[X_W-1:0];
    new_y      = ny[Y_W-1:0];
    new_color  = (upd_r_p1 && !prev_right) ? color_idx + 3'd1 : color_idx;
    paint_addr = ADDR_W'(new_y) * ADDR_W'(SCREEN_W) + ADDR_W'(new_x);
  end

  // Stage 0/1 packet data: buffer strobes while busy, hand the merged packet to UPDATE
  always_ff @(posedge clk) begin
    if (data_valid && state != IDLE) begin
      pend_dx_p0 <= mrg_dx;
      pend_dy_p0 <= mrg_dy;
      pend_l_p0  <= btn_left;
      pend_r_p0  <= btn_right;
      pend_m_p0  <= btn_middle;
    end
    if (state == IDLE) begin
      if (data_valid) begin
        upd_dx_p1 <= mrg_dx;
        upd_dy_p1 <= mrg_dy;
        upd_l_p1  <= btn_left;
        upd_r_p1  <= btn_right;
        upd_m_p1  <= btn_middle;
      end else begin
        upd_dx_p1 <= pend_dx_p0;
        upd_dy_p1 <= pend_dy_p0;
        upd_l_p1  <= pend_l_p0;
        upd_r_p1  <= pend_r_p0;
        upd_m_p1  <= pend_m_p0;
      end
    end
  end

  // Control FSM with registered cursor, colour and write-bus outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pend_full   <= 1'b0;
      cursor_x    <= X_W'(SCREEN_W / 2);
      cursor_y    <= Y_W'(SCREEN_H / 2);
      color_idx   <= 3'd1;
      prev_right  <= 1'b0;
      prev_middle <= 1'b0;
      clr_cnt     <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_color_q  <= 3'd0;
    end else begin
      if (state != IDLE && data_valid)
        pend_full <= 1'b1;
      case (state)
        IDLE: begin
          if (pend_full || data_valid)
            state <= UPDATE;
          pend_full <= 1'b0;
        end
        UPDATE: begin
          cursor_x    <= new_x;
          cursor_y    <= new_y;
          color_idx   <= new_color;
          prev_right  <= upd_r_p1;
          prev_middle <= upd_m_p1;
          if (upd_m_p1 && !prev_middle) begin
            state      <= CLEAR;
            clr_cnt    <= '0;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= '0;
            wr_color_q <= 3'd0;
          end else if (upd_l_p1) begin
            state      <= PAINT;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= paint_addr;
            wr_color_q <= new_color;
          end else begin
            state <= IDLE;
          end
        end
        PAINT: begin
          if (wr.wr_ready) begin
            wr_valid_q <= 1'b0;
            state      <= IDLE;
          end
        end
        CLEAR: begin
          if (wr.wr_ready) begin
            if (clr_cnt == LAST_ADDR) begin
              wr_valid_q <= 1'b0;
              state      <= IDLE;
            end else begin
              clr_cnt   <= clr_cnt + 1'b1;
              wr_addr_q <= clr_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr.wr_valid = wr_valid_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_color = wr_color_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cursor_paint_ctrl.sv
// Directed bench for cursor_paint_ctrl: reset, motion, clamping, paint stall,
// palette stepping, full clear and reset during clear.
module tb_cursor_paint_ctrl;

  logic              clk;
  logic              rst_n;
  logic              btn_left, btn_right, btn_middle;
  logic signed [7:0] delta_x, delta_y;
  logic              data_valid;
  logic [5:0]        cursor_x, cursor_y;
  logic [2:0]        color_idx;
  logic              busy;
  int                checks;
  int                failures;
  int                hs_cnt;
  int                hs0;

  cursor_paint_ctrl_if #(.ADDR_W(12)) wr_if ();

  cursor_paint_ctrl #(
    .SCREEN_W(64), .SCREEN_H(64), .X_W(6), .Y_W(6), .ADDR_W(12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_middle (btn_middle),
    .delta_x    (delta_x),
    .delta_y    (delta_y),
    .data_valid (data_valid),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .color_idx  (color_idx),
    .wr         (wr_if),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake counter
  initial hs_cnt = 0;
  always @(posedge clk)
    if (wr_if.wr_valid && wr_if.wr_ready)
      hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic l, input logic r, input logic m,
                      input logic [7:0] dx, input logic [7:0] dy);
    @(negedge clk);
    btn_left = l; btn_right = r; btn_middle = m;
    delta_x = dx; delta_y = dy;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic move(input logic l, input logic r, input logic m,
                      input logic [7:0] dx, input logic [7:0] dy);
    send(l, r, m, dx, dy);
    @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0;
    btn_left = 0; btn_right = 0; btn_middle = 0;
    delta_x = 0; delta_y = 0; data_valid = 0;
    wr_if.wr_ready = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_x", 32'(cursor_x), 32);
    chk("rst_y", 32'(cursor_y), 32);
    chk("rst_color", 32'(color_idx), 1);
    chk("rst_valid", 32'(wr_if.wr_valid), 0);
    chk("rst_addr", 32'(wr_if.wr_addr), 0);
    chk("rst_wcolor", 32'(wr_if.wr_color), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain motion, two-cycle latency, no write
    send(0, 0, 0, 8'd5, 8'd3);
    chk("mv_x_early", 32'(cursor_x), 32);
    chk("mv_busy", 32'(busy), 1);
    @(negedge clk);
    chk("mv_x", 32'(cursor_x), 37);
    chk("mv_y", 32'(cursor_y), 29);
    chk("mv_valid", 32'(wr_if.wr_valid), 0);
    @(negedge clk);
    chk("mv_idle", 32'(busy), 0);
    chk("mv_hs", 32'(hs_cnt), 0);

    // Clamping at all reachable edges
    move(0, 0, 0, 8'h80, 8'd0);
    chk("clamp_x0", 32'(cursor_x), 0);
    move(0, 0, 0, 8'd60, 8'd0);
    chk("x60", 32'(cursor_x), 60);
    move(0, 0, 0, 8'd127, 8'd0);
    chk("clamp_x63", 32'(cursor_x), 63);
    move(0, 0, 0, 8'd0, 8'd27);
    chk("y2", 32'(cursor_y), 2);
    move(0, 0, 0, 8'd0, 8'd10);
    chk("clamp_y0", 32'(cursor_y), 0);
    move(0, 0, 0, 8'hE6, 8'hE3);
    chk("back_x", 32'(cursor_x), 37);
    chk("back_y", 32'(cursor_y), 29);

    // Paint with stalled ready; two packets merge while stalled
    send(1, 0, 0, 8'd1, 8'd0);
    @(negedge clk);
    chk("pt_valid0", 32'(wr_if.wr_valid), 1);
    chk("pt_addr0", 32'(wr_if.wr_addr), 1894);
    chk("pt_color0", 32'(wr_if.wr_color), 1);
    btn_left = 0; delta_x = 8'd3; delta_y = 8'd0; data_valid = 1'b1;
    @(negedge clk);
    delta_x = 8'd4;
    chk("pt_valid1", 32'(wr_if.wr_valid), 1);
    chk("pt_addr1", 32'(wr_if.wr_addr), 1894);
    chk("pt_color1", 32'(wr_if.wr_color), 1);
    @(negedge clk);
    data_valid = 1'b0;
    chk("pt_valid2", 32'(wr_if.wr_valid), 1);
    chk("pt_addr2", 32'(wr_if.wr_addr), 1894);
    chk("pt_hs_none", 32'(hs_cnt), 0);
    wr_if.wr_ready = 1'b1;
    @(negedge clk);
    wr_if.wr_ready = 1'b0;
    chk("pt_valid_drop", 32'(wr_if.wr_valid), 0);
    chk("pt_hs_one", 32'(hs_cnt), 1);
    chk("pt_x", 32'(cursor_x), 38);
    chk("pt_idle", 32'(busy), 0);
    @(negedge clk);
    chk("mrg_busy", 32'(busy), 1);
    chk("mrg_x_early", 32'(cursor_x), 38);
    @(negedge clk);
    chk("mrg_x", 32'(cursor_x), 45);
    chk("mrg_y", 32'(cursor_y), 29);
    chk("mrg_nowrite", 32'(wr_if.wr_valid), 0);
    chk("mrg_hs", 32'(hs_cnt), 1);

    // Palette stepping on right-button rising edges only
    for (int i = 0; i < 6; i++) begin
      move(0, 1, 0, 8'd0, 8'd0);
      move(0, 0, 0, 8'd0, 8'd0);
    end
    chk("col7", 32'(color_idx), 7);
    move(0, 0, 0, 8'd0, 8'd0);
    chk("col_r0", 32'(color_idx), 7);
    move(0, 1, 0, 8'd0, 8'd0);
    chk("col_wrap", 32'(color_idx), 0);
    move(0, 1, 0, 8'd0, 8'd0);
    chk("col_held", 32'(color_idx), 0);
    move(0, 0, 0, 8'd0, 8'd0);
    chk("col_rel", 32'(color_idx), 0);
    move(0, 1, 0, 8'd0, 8'd0);
    chk("col_step", 32'(color_idx), 1);

    // Full clear with ready held high; left held in the same packet
    wr_if.wr_ready = 1'b1;
    send(1, 0, 1, 8'd0, 8'd0);
    hs0 = hs_cnt;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clk);
      chk("clr_valid", 32'(wr_if.wr_valid), 1);
      chk("clr_addr", 32'(wr_if.wr_addr), 32'(i));
      chk("clr_color", 32'(wr_if.wr_color), 0);
      chk("clr_busy", 32'(busy), 1);
    end
    @(negedge clk);
    chk("clr_done_valid", 32'(wr_if.wr_valid), 0);
    chk("clr_done_busy", 32'(busy), 0);
    chk("clr_count", 32'(hs_cnt - hs0), 4096);
    chk("clr_cur_x", 32'(cursor_x), 45);
    chk("clr_cur_y", 32'(cursor_y), 29);
    chk("clr_color_idx", 32'(color_idx), 1);
    @(negedge clk);
    chk("clr_no_paint", 32'(hs_cnt - hs0), 4096);

    // Reset in the middle of a clear
    move(0, 0, 0, 8'd0, 8'd0);
    send(0, 0, 1, 8'd0, 8'd0);
    repeat (10) @(negedge clk);
    chk("rc_valid", 32'(wr_if.wr_valid), 1);
    chk("rc_addr", 32'(wr_if.wr_addr), 9);
    rst_n = 1'b0;
    #1;
    chk("rc_valid_drop", 32'(wr_if.wr_valid), 0);
    chk("rc_x", 32'(cursor_x), 32);
    chk("rc_y", 32'(cursor_y), 32);
    chk("rc_busy", 32'(busy), 0);
    chk("rc_addr0", 32'(wr_if.wr_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rc_stay_idle", 32'(wr_if.wr_valid), 0);
    chk("rc_stay_busy", 32'(busy), 0);
    move(0, 0, 0, 8'd1, 8'hFF);
    chk("rc_after_x", 32'(cursor_x), 33);
    chk("rc_after_y", 32'(cursor_y), 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
